// File: rtl/rv_csr_pkg.sv
// rv_csr_pkg: definitions shared by the Zicsr execution unit.
//   - Zicsr funct3 encodings and the operation field in funct3[1:0]
//   - FSM state encoding for rv_csr_exec
//   - CSR address helper: read-only CSRs have addr[11:10] == 2'b11
package rv_csr_pkg;

  // Full funct3 encodings of the Zicsr instructions
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // Operation field funct3[1:0]; funct3[2] only selects the operand source
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_MOD  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Top two address bits that mark a read-only CSR
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  // True when the CSR whose top two address bits are given is read-only
  function automatic logic csr_is_read_only(input logic [1:0] addr_top);
    return (addr_top == CSR_RO_PREFIX);
  endfunction

endpackage

// File: rtl/rv_csr_alu.sv
// rv_csr_alu: combinational datapath for one Zicsr instruction.
// Ports:
//   funct3    in   Zicsr funct3
//   csr_addr  in   target CSR address (read-only check)
//   old_val   in   current CSR value
//   rs1_val   in   rs1 register value (register forms)
//   zimm      in   5-bit immediate / rs1 index
//   new_val   out  value to write back
//   wr_needed out  instruction writes the CSR
//   illegal   out  reserved funct3 or write to a read-only CSR
module rv_csr_alu
  import rv_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] csr_addr,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [4:0]            zimm,
  output logic [DATA_WIDTH-1:0] new_val,
  output logic                  wr_needed,
  output logic                  illegal
);

  logic [DATA_WIDTH-1:0] src;

  // Operand select, new-value computation and legality decision
  always_comb begin
    src       = '0;
    new_val   = '0;
    wr_needed = 1'b0;
    illegal   = 1'b0;

    if (funct3[2]) begin
      src = {{(DATA_WIDTH-5){1'b0}}, zimm};
    end else begin
      src = rs1_val;
    end

    // zimm is also the rs1 index, so "rs1 == x0" and "zimm == 0" are the same test
    case (funct3[1:0])
      OP_RW: begin
        new_val   = src;
        wr_needed = 1'b1;
      end
      OP_RS: begin
        new_val   = old_val | src;
        wr_needed = (zimm != 5'd0);
      end
      OP_RC: begin
        new_val   = old_val & ~src;
        wr_needed = (zimm != 5'd0);
      end
      default: begin
        new_val   = old_val;
        wr_needed = 1'b0;
      end
    endcase

    if (funct3[1:0] == OP_NONE) begin
      illegal = 1'b1;
    end else if (wr_needed && csr_is_read_only(csr_addr[ADDR_WIDTH-1 -: 2])) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/rv_csr_exec.sv
// rv_csr_exec: executes one Zicsr instruction per request against the CSR
// register file: read old value, compute new value, write back, return old.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_*                        request from issue (valid/ready handshake)
//   csr_addr_out / csr_out       registered read port (data one clk after addr)
//   csr_addr_in / csr_in         write port, strobed by csr_wr and en
//   rsp_*                        response to writeback (valid/ready handshake)
// Sequence: IDLE -> RD -> MOD -> RESP -> IDLE.
module rv_csr_exec
  import rv_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TID_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_rs1_val,
  input  logic [4:0]            req_rs1_idx,
  input  logic [4:0]            req_rd,
  input  logic [TID_WIDTH-1:0]  req_tid,
  output logic [ADDR_WIDTH-1:0] csr_addr_out,
  input  logic [DATA_WIDTH-1:0] csr_out,
  output logic [ADDR_WIDTH-1:0] csr_addr_in,
  output logic [DATA_WIDTH-1:0] csr_in,
  output logic                  csr_wr,
  output logic                  en,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_illegal,
  output logic [TID_WIDTH-1:0]  rsp_tid
);

  logic [1:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
  logic [4:0]            rs1_idx_q, rs1_idx_d;
  logic [4:0]            rd_q, rd_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic [ADDR_WIDTH-1:0] csr_addr_out_q, csr_addr_out_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_illegal_q, rsp_illegal_d;
  logic [TID_WIDTH-1:0]  rsp_tid_q, rsp_tid_d;

  logic [DATA_WIDTH-1:0] alu_new;
  logic                  alu_wr_needed;
  logic                  alu_illegal;
  logic                  accept;
  logic                  do_write;

  // csr_out is the old value only while in MOD; elsewhere the ALU result is unused
  rv_csr_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_alu (
    .funct3    (funct3_q),
    .csr_addr  (addr_q),
    .old_val   (csr_out),
    .rs1_val   (rs1_val_q),
    .zimm      (rs1_idx_q),
    .new_val   (alu_new),
    .wr_needed (alu_wr_needed),
    .illegal   (alu_illegal)
  );

  // Handshake and write-strobe decode; rst_n kills a write pending in MOD
  always_comb begin
    accept   = (state_q == ST_IDLE) && req_ready_q && req_valid;
    do_write = (state_q == ST_MOD) && alu_wr_needed && !alu_illegal && rst_n;
  end

  // Next-state and register update logic
  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    rs1_val_d      = rs1_val_q;
    rs1_idx_d      = rs1_idx_q;
    rd_d           = rd_q;
    tid_d          = tid_q;
    csr_addr_out_d = '0;
    rsp_valid_d    = rsp_valid_q;
    rsp_rd_d       = rsp_rd_q;
    rsp_we_d       = rsp_we_q;
    rsp_data_d     = rsp_data_q;
    rsp_illegal_d  = rsp_illegal_q;
    rsp_tid_d      = rsp_tid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d        = ST_RD;
          funct3_d       = req_funct3;
          addr_d         = req_csr_addr;
          rs1_val_d      = req_rs1_val;
          rs1_idx_d      = req_rs1_idx;
          rd_d           = req_rd;
          tid_d          = req_tid;
          // Registered so the read address is presented for the RD cycle only
          csr_addr_out_d = req_csr_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_MOD;
      end
      ST_MOD: begin
        state_d       = ST_RESP;
        rsp_valid_d   = 1'b1;
        rsp_rd_d      = rd_q;
        rsp_tid_d     = tid_q;
        rsp_illegal_d = alu_illegal;
        rsp_we_d      = !alu_illegal && (rd_q != 5'd0);
        if (alu_illegal) begin
          rsp_data_d = '0;
        end else begin
          rsp_data_d = csr_out;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rd_d      = 5'd0;
          rsp_we_d      = 1'b0;
          rsp_data_d    = '0;
          rsp_illegal_d = 1'b0;
          rsp_tid_d     = '0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b0;
      funct3_q       <= 3'd0;
      addr_q         <= '0;
      rs1_val_q      <= '0;
      rs1_idx_q      <= 5'd0;
      rd_q           <= 5'd0;
      tid_q          <= '0;
      csr_addr_out_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rd_q       <= 5'd0;
      rsp_we_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_illegal_q  <= 1'b0;
      rsp_tid_q      <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      rs1_val_q      <= rs1_val_d;
      rs1_idx_q      <= rs1_idx_d;
      rd_q           <= rd_d;
      tid_q          <= tid_d;
      csr_addr_out_q <= csr_addr_out_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rd_q       <= rsp_rd_d;
      rsp_we_q       <= rsp_we_d;
      rsp_data_q     <= rsp_data_d;
      rsp_illegal_q  <= rsp_illegal_d;
      rsp_tid_q      <= rsp_tid_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign csr_addr_out = csr_addr_out_q;
  // The write port depends on csr_out, which only arrives in MOD, so it is
  // decoded from state rather than registered; it is zero outside a write.
  assign csr_wr       = do_write;
  assign en           = do_write;
  assign csr_addr_in  = do_write ? addr_q  : '0;
  assign csr_in       = do_write ? alu_new : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rd       = rsp_rd_q;
  assign rsp_we       = rsp_we_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign rsp_tid      = rsp_tid_q;

endmodule
